// File: rtl/wavuno_pkg.sv
// Shared constants and types for the WAV add-on sample playback path.
package wavuno_pkg;

    typedef logic [7:0] sample_t;

    localparam sample_t    SAMPLE_MID       = 8'h80;
    localparam logic [8:0] BEEPER_WEIGHT    = 9'd255;
    localparam logic [15:0] DEFAULT_RATE_DIV = 16'd634;

endpackage

// File: rtl/wavuno_fifo.sv
// Sample FIFO: synchronous-write / synchronous-read RAM with registered level and flags.
module wavuno_fifo
    import wavuno_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  sample_t         wr_data,
    input  logic            push_req,
    input  logic            pop_req,
    input  logic            flush,
    output sample_t         rd_data,
    output logic            rd_vld,
    output logic [ADDR_W:0] level,
    output logic            full,
    output logic            empty
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              rd_vld_q, rd_vld_d;
    logic              push, pop;

    sample_t mem [DEPTH];
    sample_t rd_data_q;

    // Fullness/emptiness are judged on the registered pre-cycle state; flush discards both requests.
    always_comb begin
        push     = push_req && !full_q && !flush;
        pop      = pop_req && !empty_q && !flush;
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + ADDR_W'(pop);
        level_d  = flush ? '0 : level_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
        full_d   = (level_d == FULL_LEVEL);
        empty_d  = (level_d == '0);
        rd_vld_d = pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rd_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // RAM array and its output register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
        if (pop)  rd_data_q     <= mem[rd_ptr_q];
    end

    assign rd_data = rd_data_q;
    assign rd_vld  = rd_vld_q;
    assign level   = level_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/wavuno_sample_dac.sv
// WAV playback stage: sample FIFO, programmable sample-rate tick, beeper mix and
// first-order sigma-delta 1-bit output.
module wavuno_sample_dac
    import wavuno_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        wr_data,
    input  logic              wr_strobe,
    input  logic              fifo_flush,
    input  logic              clr_flags,
    input  logic              play_enable,
    input  logic [RATE_W-1:0] rate_div,
    input  logic              beeper,
    output logic [7:0]        cur_sample,
    output logic              dac_out,
    output logic [ADDR_W:0]   fifo_level,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              half_empty,
    output logic              overflow,
    output logic              underrun
);
    localparam logic [ADDR_W:0] HALF_LEVEL = (ADDR_W + 1)'(1 << (ADDR_W - 1));

    function automatic logic [9:0] mix_level(input sample_t s, input logic beep);
        mix_level = {2'b00, s} + (beep ? {1'b0, BEEPER_WEIGHT} : 10'd0);
    endfunction

    function automatic logic [10:0] sd_sum(input logic [8:0] acc, input logic [9:0] mix);
        sd_sum = {2'b00, acc} + {1'b0, mix};
    endfunction

    logic [RATE_W-1:0] cnt_q, cnt_d;
    sample_t           cur_q, cur_d;
    logic [8:0]        acc_q, acc_d;
    logic              dac_q, dac_d;
    logic              overflow_q, overflow_d;
    logic              underrun_q, underrun_d;
    logic              tick;
    logic [9:0]        mix;
    logic [10:0]       sum;
    sample_t           rd_data;
    logic              rd_vld;

    wavuno_fifo #(.ADDR_W(ADDR_W)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .push_req (wr_strobe),
        .pop_req  (tick),
        .flush    (fifo_flush),
        .rd_data  (rd_data),
        .rd_vld   (rd_vld),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        // Counter parks at 0 while stopped so the first enabled cycle ticks immediately.
        tick = play_enable && (cnt_q == '0);
        if (!play_enable)  cnt_d = '0;
        else if (tick)     cnt_d = rate_div;
        else               cnt_d = cnt_q - RATE_W'(1);

        overflow_d = (wr_strobe && fifo_full) || (overflow_q && !clr_flags);
        underrun_d = (tick && fifo_empty) || (underrun_q && !clr_flags);

        if (!play_enable)  cur_d = SAMPLE_MID;
        else if (rd_vld)   cur_d = rd_data;
        else               cur_d = cur_q;

        mix   = mix_level(cur_q, beeper);
        sum   = sd_sum(acc_q, mix);
        acc_d = sum[8:0];
        dac_d = sum[9] | sum[10];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            cur_q      <= SAMPLE_MID;
            acc_q      <= '0;
            dac_q      <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            dac_q      <= dac_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign cur_sample = cur_q;
    assign dac_out    = dac_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;
    assign half_empty = play_enable && (fifo_level < HALF_LEVEL);

endmodule
